// File: rtl/carry_shift_sequencer.sv
// Purpose: iterative one-bit-per-clock shifter (shll/shrl/shra) that also
// reports the last bit shifted out for the processor carry flag.
// Latency: n+1 cycles from accepted start to done, with n = min(shamt, WIDTH) and n = 0 for op 11.
// Backpressure: none; start is ignored while busy, with no queuing.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   start, op          request pulse and shift kind (00 shll, 01 shrl, 10 shra, 11 no-op)
//   data_in, shamt     operand and shift amount, both sampled with an accepted start
//   busy, done         busy in SHIFT/DONE; done is a one-cycle completion pulse
//   result, carry_out  shifted value and last bit shifted out, held until the next start
//   carry_we           carry register write enable; pulses with done only if a bit was shifted
module carry_shift_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] shamt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             carry_we
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] OP_SHLL = 2'b00;
   localparam logic [1:0] OP_SHRL = 2'b01;
   localparam logic [1:0] OP_SHRA = 2'b10;
   localparam logic [1:0] OP_NONE = 2'b11;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] n_start;
   logic [1:0]       op_q;
   logic             shifted;

   // The full shamt word is compared, so any large register value
   // saturates to WIDTH instead of wrapping in the narrow counter.
   always_comb begin
      n_start = '0;
      if (op == OP_NONE) begin
         n_start = '0;
      end else if (shamt >= WIDTH'(WIDTH)) begin
         n_start = CNT_W'(WIDTH);
      end else begin
         n_start = shamt[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      carry_we  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (n_start == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (cnt == CNT_W'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            // A zero-length shift leaves a stale carry_out; keep it out of the flag.
            carry_we  = shifted;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result    <= '0;
         carry_out <= 1'b0;
         cnt       <= '0;
         op_q      <= OP_SHLL;
         shifted   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  result  <= data_in;
                  op_q    <= op;
                  cnt     <= n_start;
                  shifted <= (n_start != '0);
               end
            end
            SHIFT: begin
               cnt <= cnt - CNT_W'(1);
               case (op_q)
                  OP_SHLL: begin
                     carry_out <= result[WIDTH-1];
                     result    <= {result[WIDTH-2:0], 1'b0};
                  end
                  OP_SHRL: begin
                     carry_out <= result[0];
                     result    <= {1'b0, result[WIDTH-1:1]};
                  end
                  OP_SHRA: begin
                     carry_out <= result[0];
                     result    <= {result[WIDTH-1], result[WIDTH-1:1]};
                  end
                  default: begin
                     // op 11 never enters SHIFT; hold everything
                     result <= result;
                  end
               endcase
            end
            default: begin
               result <= result;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_carry_shift_sequencer.sv
module tb_carry_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] data_in;
   logic [31:0] shamt;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        carry_out;
   logic        carry_we;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   carry_shift_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .data_in   (data_in),
      .shamt     (shamt),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .carry_we  (carry_we)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] data;
      logic [31:0] shamt;
      logic [31:0] exp_result;
      logic        exp_carry;
      logic        exp_we;
      int          exp_lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: shift the whole operand by n in one step with wide arithmetic.
   function automatic void model(input logic [1:0] o, input logic [31:0] d, input logic [31:0] s,
                                 output logic [31:0] r, output logic c, output int n);
      logic [63:0] wide;
      n = (s >= 32) ? 32 : int'(s);
      if (o == 2'b11) n = 0;
      r = d;
      c = 1'b0;
      if (n > 0) begin
         case (o)
            2'b00: begin
               wide = {32'd0, d} << n;
               r = wide[31:0];
               c = d[32-n];
            end
            2'b01: begin
               wide = {32'd0, d} >> n;
               r = wide[31:0];
               c = d[n-1];
            end
            default: begin
               wide = {{32{d[31]}}, d} >> n;
               r = wide[31:0];
               c = d[n-1];
            end
         endcase
      end
   endfunction

   // Issues one operation; optionally keeps start asserted through SHIFT/DONE
   // with scrambled inputs to prove they are ignored.
   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                        input logic [31:0] s, input logic [31:0] exp_r, input logic exp_c,
                        input logic exp_we, input int exp_lat, input bit spam);
      int lat;
      @(negedge clk);
      start = 1'b1; op = o; data_in = d; shamt = s;
      @(negedge clk);
      lat = 1;
      start = spam;
      data_in = $urandom; shamt = $urandom; op = 2'($urandom);
      while (!done && lat < 40) begin
         if (busy !== 1'b1) begin
            chk({tag, " busy_during"}, {31'd0, busy}, 32'd1);
         end
         if (carry_we !== 1'b0) begin
            chk({tag, " early_we"}, {31'd0, carry_we}, 32'd0);
         end
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd1);
      chk({tag, " result"}, result, exp_r);
      chk({tag, " carry_we"}, {31'd0, carry_we}, {31'd0, exp_we});
      if (exp_we) chk({tag, " carry_out"}, {31'd0, carry_out}, {31'd0, exp_c});
      @(negedge clk);
      start = 1'b0;
      chk({tag, " done_pulse_once"}, {31'd0, done}, 32'd0);
      chk({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, " held_result"}, result, exp_r);
      if (exp_we) chk({tag, " held_carry"}, {31'd0, carry_out}, {31'd0, exp_c});
   endtask

   vec_t vecs[7];

   initial begin
      logic [31:0] r;
      logic        c;
      int          n;
      logic [1:0]  ro;
      logic [31:0] rd;
      logic [31:0] rs;
      bit          saw_we;

      rst = 1'b1; start = 1'b0; op = 2'b00; data_in = '0; shamt = '0;
      repeat (3) @(negedge clk);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst carry_we", {31'd0, carry_we}, 32'd0);
      chk("rst result", result, 32'd0);
      chk("rst carry_out", {31'd0, carry_out}, 32'd0);
      rst = 1'b0;

      vecs[0] = '{2'b00, 32'h80000001, 32'd1,          32'h00000002, 1'b1, 1'b1, 2};
      vecs[1] = '{2'b10, 32'hF0000008, 32'd4,          32'hFF000000, 1'b1, 1'b1, 5};
      vecs[2] = '{2'b01, 32'hF0000008, 32'd4,          32'h0F000000, 1'b1, 1'b1, 5};
      vecs[3] = '{2'b01, 32'h12345678, 32'hFFFFFFFF,   32'h00000000, 1'b0, 1'b1, 33};
      vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF,   32'hFFFFFFFF, 1'b1, 1'b1, 33};
      vecs[5] = '{2'b00, 32'hDEADBEEF, 32'd0,          32'hDEADBEEF, 1'b0, 1'b0, 1};
      vecs[6] = '{2'b11, 32'hDEADBEEF, 32'd5,          32'hDEADBEEF, 1'b0, 1'b0, 1};
      for (int i = 0; i < 7; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].shamt,
               vecs[i].exp_result, vecs[i].exp_carry, vecs[i].exp_we, vecs[i].exp_lat, 1'b0);
      end

      // Restarts pulsed through SHIFT and DONE are dropped; the next start is taken.
      do_op("ignore", 2'b00, 32'h0000000F, 32'd3, 32'h00000078, 1'b0, 1'b1, 4, 1'b1);
      do_op("after_ignore", 2'b01, 32'h00000005, 32'd1, 32'h00000002, 1'b1, 1'b1, 2, 1'b0);

      // Reset sampled at E2 of a 10-bit shift aborts it without a carry write.
      @(negedge clk);
      start = 1'b1; op = 2'b00; data_in = 32'hFFFFFFFF; shamt = 32'd10;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort done", {31'd0, done}, 32'd0);
      chk("abort result", result, 32'd0);
      chk("abort carry_out", {31'd0, carry_out}, 32'd0);
      saw_we = 1'b0;
      for (int k = 0; k < 15; k++) begin
         if (carry_we || done) saw_we = 1'b1;
         @(negedge clk);
      end
      chk("abort no_we", {31'd0, saw_we}, 32'd0);
      do_op("post_abort", 2'b10, 32'h80000001, 32'd2, 32'hE0000000, 1'b0, 1'b1, 3, 1'b0);

      // Random operations against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom);
         rd = $urandom;
         case ($urandom_range(0, 3))
            0: rs = $urandom;
            1: rs = 32'($urandom_range(0, 32));
            2: rs = 32'($urandom_range(30, 34));
            default: rs = 32'($urandom_range(0, 5));
         endcase
         model(ro, rd, rs, r, c, n);
         do_op($sformatf("rand%0d", i), ro, rd, rs, r, c, (n > 0), n + 1, i[0]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/carry_shift_sequencer.md
Name: carry_shift_sequencer

Overview:
- Multi-cycle iterative shifter for the KGP-RISC shift class: shll, shrl, shra and their variable forms shllv, shrlv, shrav. It shifts one bit per clock.
- Captures the last bit shifted out and presents it with a write-enable to the processor's 1-bit carry flag register, so that bcy/bncy see shift carries.
- Sits between the decode/control unit (start/op handshake) and the datapath (result bus, carry flag input).

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, width of the internal shift counter; must hold the value WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  00 = shll, 01 = shrl, 10 = shra, 11 = reserved.
- data_in  input  WIDTH  operand to shift; sampled with start.
- shamt  input  WIDTH  shift amount (immediate zero-extended, or register value); sampled with start.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse; result and carry_out are valid.
- result  output  WIDTH  shifted value; held from done until the next accepted start.
- carry_out  output  1  last bit shifted out; connects to the carry register input.
- carry_we  output  1  pulses with done only when at least one bit was shifted; gates the carry register update.

Behaviour:
- Reset: clock clk, synchronous active-high reset rst. With rst=1 at an edge: state=IDLE, busy=0, done=0, carry_we=0, result=0, carry_out=0, counter=0. Reset mid-SHIFT or mid-DONE aborts the operation: no done pulse, no carry_we.
- FSM states: IDLE, SHIFT, DONE.
- IDLE with start=1 at edge E0:
  - Latch data_in into result and latch op.
  - n = min(shamt, WIDTH), computed unsigned over the full WIDTH bits. Any shamt >= WIDTH saturates to WIDTH.
  - op=11 forces n=0.
  - If n=0, go to DONE; otherwise go to SHIFT with counter=n.
- SHIFT, each edge:
  - shll: carry_out <= result[WIDTH-1]; result <= result<<1, zero fill.
  - shrl: carry_out <= result[0]; result <= result>>1, zero fill.
  - shra: carry_out <= result[0]; result <= result>>1, fill with result[WIDTH-1].
  - counter decrements; when counter==1 at the edge, go to DONE.
- DONE: lasts exactly one cycle.
  - done=1.
  - carry_we=1 iff n>=1. carry_out is unchanged from the last shift; when n=0 the previous carry_out value is unused because carry_we=0.
  - Next state IDLE unconditionally.
- Latency: done is high in the cycle following edge E0+n, so total latency is n+1 cycles, with n=0 → done in the cycle after E0. Maximum is WIDTH+1 cycles.
- start while busy=1 (SHIFT or DONE) is ignored: no queuing, no error. The next start is accepted in IDLE, earliest one cycle after DONE.
- data_in, shamt and op changes during busy have no effect.
- result and carry_out hold their values in IDLE until the next accepted start. done and carry_we are 0 outside DONE.
- Saturated shifts:
  - shll/shrl by >= WIDTH: result=0.
  - shra by >= WIDTH: result = all copies of the sign bit.
  - carry_out = bit WIDTH-n of the original operand for left shifts, bit n-1 for right shifts. At n=WIDTH this is data_in[0] (shll) or data_in[WIDTH-1] (shrl/shra).

Test Plan:
- Reset, then shll data_in=0x80000001, shamt=1 → done in the cycle after E1; result=0x00000002, carry_out=1, carry_we=1, busy high for exactly 2 cycles.
- shra data_in=0xF0000008, shamt=4 → done after E4; result=0xFF000000, carry_out=1. Then shrl same operand, shamt=4 → result=0x0F000000, carry_out=1.
- shrlv data_in=0x12345678, shamt=0xFFFFFFFF (saturate) → done after E32; result=0, carry_out=0 (bit31=0), carry_we=1. Same with shra on 0x80000000 → result=0xFFFFFFFF, carry_out=1.
- shamt=0, and separately op=11 with shamt=5, data_in=0xDEADBEEF → done in the cycle after E0; result=0xDEADBEEF, carry_we=0, busy high for 1 cycle.
- Second start pulsed during SHIFT and again during DONE of a shamt=3 operation → both ignored; exactly one done pulse. A start one cycle after DONE is accepted.
- rst asserted at E2 of a shamt=10 operation → next cycle busy=0, done=0, result=0, carry_out=0; no carry_we pulse ever occurs. A new start afterwards completes normally.
